mem_copy_master: RTL
====================

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, word-address width of the target memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  high only in IDLE; command accepted on cmd_valid & cmd_ready.
REQ-007 SHALL have port cmd_mode  input  1  0 = copy, 1 = fill.
REQ-008 SHALL have port cmd_src  input  ADDR_W  copy source word address (ignored in fill).
REQ-009 SHALL have port cmd_dst  input  ADDR_W  destination word address.
REQ-010 SHALL have port cmd_len  input  ADDR_W+1  word count, 0..2^ADDR_W.
REQ-011 SHALL have port cmd_fill  input  DATA_W  fill pattern.
REQ-012 SHALL have port busy  output  1  high from acceptance until done.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port m_address  output  ADDR_W  memory word address.
REQ-015 SHALL have port m_byteenable  output  DATA_W/8  byte lanes; always all-ones.
REQ-016 SHALL have port m_chipselect  output  1  memory access strobe.
REQ-017 SHALL have port m_write  output  1  1 = write, 0 = read when m_chipselect.
REQ-018 SHALL have port m_writedata  output  DATA_W  write data.
REQ-019 SHALL have port m_clken  output  1  memory clock enable; 0 in reset, otherwise 1.
REQ-020 SHALL have port m_readdata  input  DATA_W  memory read data, valid exactly one cycle after read address is presented.

Function
REQ-021 SHALL implement states IDLE, RD, RDW, WR, FILL, FIN.
REQ-022 On acceptance SHALL latch src, dst, len, fill, mode; len=0 -> FIN; mode=1 -> FILL; else RD.
REQ-023 RD: m_chipselect=1, m_write=0, m_address=src pointer; next RDW.
REQ-024 RDW: m_chipselect=0; at end of cycle SHALL capture m_readdata into hold register; next WR.
REQ-025 WR: m_chipselect=1, m_write=1, m_address=dst pointer, m_writedata=hold; decrement remaining, increment both pointers; next RD if remaining>1, else FIN.
REQ-026 Copy throughput SHALL be exactly 3 cycles per word.
REQ-027 FILL: one write per cycle of cmd_fill to dst pointer; stays in FILL until last word, then FIN; throughput 1 word/cycle.
REQ-028 Pointers SHALL wrap modulo 2^ADDR_W (8191+1 -> 0) without error.
REQ-029 cmd_len=2^ADDR_W SHALL transfer all 8192 words.
REQ-030 FIN: done=1 for one cycle, busy=0, bus idle; next IDLE (cmd_ready=1 the following cycle).
REQ-031 Overlapping copy regions SHALL be processed in ascending address order with no hazard handling.
REQ-032 cmd_valid while not IDLE SHALL be ignored; inputs only sampled on acceptance.
REQ-033 m_chipselect=0 SHALL force m_write=0; m_writedata value is don't-care outside WR/FILL.

Reset
REQ-034 Reset SHALL force IDLE, cmd_ready=0 during reset and 1 after, busy=0, done=0, m_chipselect=0, m_write=0, m_address=0, m_writedata=0, m_clken=0.
REQ-035 Reset asserted mid-transfer SHALL abort on the next edge with no further bus cycles and no done pulse.

Verification
REQ-036 Fill dst=0x0010 len=4 fill=0xA5A5A5A5 -> writes to 0x10..0x13 on 4 consecutive cycles, done 1 cycle after last write.
REQ-037 Copy src=0x0100 dst=0x0200 len=3 with mem[0x100..0x102]=1,2,3 -> mem[0x200..0x202]=1,2,3, 9 bus-phase cycles, single done pulse.
REQ-038 Copy src=0x1FFE dst=0x0000 len=4 -> reads 0x1FFE,0x1FFF,0x0000,0x0001 in order, wrap correct.
REQ-039 len=0 -> no m_chipselect, done pulse 1 cycle after acceptance.
REQ-040 Reset asserted at 2nd WR of len=8 copy -> only 1 word written, busy=0, done never pulses, next command runs normally.
REQ-041 cmd_valid held high during busy -> exactly one command executed per IDLE acceptance.

Source files
------------

// File: rtl/mem_copy_master_if.sv
// Command and memory-bus bundle for mem_copy_master.
// The master modport is the engine's view; slave is the command source / memory side.
interface mem_copy_master_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_mode;
    logic [ADDR_W-1:0]     cmd_src;
    logic [ADDR_W-1:0]     cmd_dst;
    logic [ADDR_W:0]       cmd_len;
    logic [DATA_W-1:0]     cmd_fill;
    logic                  busy;
    logic                  done;
    logic [ADDR_W-1:0]     m_address;
    logic [DATA_W/8-1:0]   m_byteenable;
    logic                  m_chipselect;
    logic                  m_write;
    logic [DATA_W-1:0]     m_writedata;
    logic                  m_clken;
    logic [DATA_W-1:0]     m_readdata;

    modport master (
        input  cmd_valid, cmd_mode, cmd_src, cmd_dst, cmd_len, cmd_fill, m_readdata,
        output cmd_ready, busy, done, m_address, m_byteenable, m_chipselect,
               m_write, m_writedata, m_clken
    );

    modport slave (
        output cmd_valid, cmd_mode, cmd_src, cmd_dst, cmd_len, cmd_fill, m_readdata,
        input  cmd_ready, busy, done, m_address, m_byteenable, m_chipselect,
               m_write, m_writedata, m_clken
    );
endinterface

// File: rtl/mem_copy_master.sv
// Memory copy / fill engine: copies cmd_len words from src to dst (3 cycles
// per word: read, wait, write) or fills dst with a pattern (1 word per cycle).
// Pointers wrap modulo 2^ADDR_W; overlapping regions are walked in ascending order.
module mem_copy_master #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_copy_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD, RDW, WR, FILL, FIN} state_t;

    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]   hold_q, hold_d;

    logic                ready;
    logic                busy;
    logic                done;
    logic                cs;
    logic                wr;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;

    // State and datapath registers; reset drops any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            fill_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic and bus strobes decoded from the current state.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
        hold_d  = hold_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        cs      = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        wdata   = '0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.cmd_valid) begin
                    src_d  = bus.cmd_src;
                    dst_d  = bus.cmd_dst;
                    rem_d  = bus.cmd_len;
                    fill_d = bus.cmd_fill;
                    if (bus.cmd_len == '0)  state_d = FIN;
                    else if (bus.cmd_mode)  state_d = FILL;
                    else                    state_d = RD;
                end
            end
            RD: begin
                busy    = 1'b1;
                cs      = 1'b1;
                addr    = src_q;
                state_d = RDW;
            end
            RDW: begin
                busy    = 1'b1;
                hold_d  = bus.m_readdata;
                state_d = WR;
            end
            WR: begin
                busy    = 1'b1;
                cs      = 1'b1;
                wr      = 1'b1;
                addr    = dst_q;
                wdata   = hold_q;
                rem_d   = rem_q - LEN_ONE;
                src_d   = src_q + ADDR_W'(1);
                dst_d   = dst_q + ADDR_W'(1);
                state_d = (rem_q > LEN_ONE) ? RD : FIN;
            end
            FILL: begin
                busy    = 1'b1;
                cs      = 1'b1;
                wr      = 1'b1;
                addr    = dst_q;
                wdata   = fill_q;
                rem_d   = rem_q - LEN_ONE;
                dst_d   = dst_q + ADDR_W'(1);
                state_d = (rem_q > LEN_ONE) ? FILL : FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is high so a reset landing on a
    // write cycle suppresses that write immediately.
    always_comb begin
        bus.cmd_ready    = ready & ~reset;
        bus.busy         = busy & ~reset;
        bus.done         = done & ~reset;
        bus.m_chipselect = cs & ~reset;
        bus.m_write      = wr & ~reset;
        bus.m_address    = reset ? '0 : addr;
        bus.m_writedata  = reset ? '0 : wdata;
        bus.m_clken      = ~reset;
        bus.m_byteenable = '1;
    end
endmodule
